// File: rtl/fir_serial_mac.sv
// Serial-MAC FIR: one signed multiply-accumulate per cycle over a circular sample history,
// with runtime-writable coefficients and a rounded, saturated Q-format output.
module fir_serial_mac #(
  parameter int WIDTH = 16,
  parameter int NTAPS = 8,
  parameter int FRAC  = 8
) (
  input  logic                       clock,
  input  logic                       nreset,
  input  logic signed [WIDTH-1:0]    xn,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic signed [WIDTH-1:0]    yn,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic signed [WIDTH-1:0]    coef_data,
  output logic                       busy
);

  localparam int AW   = $clog2(NTAPS);
  localparam int ACCW = 2 * WIDTH + AW;
  localparam int RW   = ACCW + 1;
  localparam int NTM  = NTAPS % (2 ** AW);
  localparam logic [AW-1:0] NT_MOD = NTM[AW-1:0];
  localparam logic [AW-1:0] K_LAST = AW'(NTAPS - 1);
  localparam logic [AW:0]   NT_W   = (AW + 1)'(NTAPS);
  localparam logic signed [RW-1:0] MAXV = RW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] MINV = RW'(-(2 ** (WIDTH - 1)));

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUT} state_t;

  state_t                   state_q, state_d;
  logic signed [WIDTH-1:0]  hist_q [NTAPS];
  logic signed [WIDTH-1:0]  coef_q [NTAPS];
  logic signed [ACCW-1:0]   acc_q;
  logic [AW-1:0]            k_q;
  logic [AW-1:0]            wptr_q;
  logic signed [WIDTH-1:0]  yn_q;

  logic [AW-1:0]            rd_idx;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [RW-1:0]     acc_ext, rnd, shifted;
  logic signed [WIDTH-1:0]  sat;
  logic                     accept, coef_ok;

  // Modulo-NTAPS distance back from the newest sample; correct for non-power-of-2 NTAPS too.
  always_comb rd_idx = wptr_q - k_q + ((wptr_q < k_q) ? NT_MOD : '0);

  assign prod    = hist_q[rd_idx] * coef_q[k_q];
  assign accept  = (state_q == S_IDLE) && in_valid;
  assign coef_ok = (state_q == S_IDLE) && coef_we && ({1'b0, coef_addr} < NT_W);
  assign acc_ext = {acc_q[ACCW-1], acc_q};

  generate
    if (FRAC > 0) begin : g_round
      localparam logic signed [RW-1:0] HALF = RW'(1) << (FRAC - 1);
      assign rnd = acc_ext + HALF;
    end else begin : g_noround
      assign rnd = acc_ext;
    end
  endgenerate

  assign shifted = rnd >>> FRAC;

  always_comb begin
    sat = shifted[WIDTH-1:0];
    if (shifted > MAXV)      sat = MAXV[WIDTH-1:0];
    else if (shifted < MINV) sat = MINV[WIDTH-1:0];
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_MAC;
      S_MAC:   if (k_q == K_LAST) state_d = S_ROUND;
      S_ROUND: state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_OUT);
  end

  assign yn = yn_q;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      acc_q  <= '0;
      k_q    <= '0;
      wptr_q <= '0;
      yn_q   <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      // Coefficient write lands on the accept edge, so that sample already uses it.
      if (coef_ok) coef_q[coef_addr] <= coef_data;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            hist_q[wptr_q] <= xn;
            acc_q          <= '0;
            k_q            <= '0;
          end
        end
        S_MAC: begin
          acc_q <= acc_q + {{AW{prod[2*WIDTH-1]}}, prod};
          k_q   <= (k_q == K_LAST) ? '0 : k_q + AW'(1);
        end
        S_ROUND: yn_q <= sat;
        S_OUT: begin
          if (out_ready) wptr_q <= (wptr_q == K_LAST) ? '0 : wptr_q + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
